// File: rtl/alu_core.sv
// Registered 16-operation ALU: operands are zero-extended to 2N bits and the
// selected result is captured on every rising clock edge (latency 1, throughput 1).
module alu_core #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op_code,
    input  logic [N-1:0]     inp1,
    input  logic [N-1:0]     inp2,
    output logic [2*N-1:0]   outp
);

    localparam int W = 2 * N;
    localparam logic [W-1:0] ONE_W       = W'(1);
    localparam logic [W-1:0] SHIFT_LIMIT = W'(W);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NAND = 4'd6,
        OP_NOR  = 4'd7,
        OP_XNOR = 4'd8,
        OP_NOTA = 4'd9,
        OP_SHL  = 4'd10,
        OP_SHR  = 4'd11,
        OP_INC  = 4'd12,
        OP_DEC  = 4'd13,
        OP_EQ   = 4'd14,
        OP_GT   = 4'd15
    } op_e;

    logic [W-1:0] a_ext;
    logic [W-1:0] b_ext;
    logic [W-1:0] result;
    logic         shift_oob;

    assign a_ext = {{N{1'b0}}, inp1};
    assign b_ext = {{N{1'b0}}, inp2};

    // Shift amounts of 2N or more would move every bit out, so force zero explicitly.
    assign shift_oob = (b_ext >= SHIFT_LIMIT);

    always_comb begin
        result = '0;
        case (op_e'(op_code))
            OP_ADD:  result = a_ext + b_ext;
            OP_SUB:  result = a_ext - b_ext;
            OP_MUL:  result = a_ext * b_ext;
            OP_AND:  result = a_ext & b_ext;
            OP_OR:   result = a_ext | b_ext;
            OP_XOR:  result = a_ext ^ b_ext;
            OP_NAND: result = {{N{1'b0}}, ~(inp1 & inp2)};
            OP_NOR:  result = {{N{1'b0}}, ~(inp1 | inp2)};
            OP_XNOR: result = {{N{1'b0}}, ~(inp1 ^ inp2)};
            OP_NOTA: result = {{N{1'b0}}, ~inp1};
            OP_SHL:  result = shift_oob ? '0 : (a_ext << inp2);
            OP_SHR:  result = shift_oob ? '0 : (a_ext >> inp2);
            OP_INC:  result = a_ext + ONE_W;
            OP_DEC:  result = a_ext - ONE_W;
            OP_EQ:   result = {{(W-1){1'b0}}, (inp1 == inp2)};
            OP_GT:   result = {{(W-1){1'b0}}, (inp1 > inp2)};
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outp <= '0;
        end else begin
            outp <= result;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core (N=4): the driver queues expected results,
// a monitor pops and compares one entry per clock after each rising edge.
module tb_alu_core;

    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic [3:0]     op_code;
    logic [N-1:0]   inp1;
    logic [N-1:0]   inp2;
    logic [2*N-1:0] outp;

    typedef struct {
        logic [7:0] expected;
        string      name;
    } sb_entry_t;

    sb_entry_t exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    alu_core #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .op_code (op_code),
        .inp1    (inp1),
        .inp2    (inp2),
        .outp    (outp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Independent integer model of the operation table for N=4.
    function automatic logic [7:0] model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int ai;
        int bi;
        int r;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        case (op)
            4'd0:  r = ai + bi;
            4'd1:  r = (ai - bi) & 255;
            4'd2:  r = ai * bi;
            4'd3:  r = ai & bi;
            4'd4:  r = ai | bi;
            4'd5:  r = ai ^ bi;
            4'd6:  r = (~(ai & bi)) & 15;
            4'd7:  r = (~(ai | bi)) & 15;
            4'd8:  r = (~(ai ^ bi)) & 15;
            4'd9:  r = (~ai) & 15;
            4'd10: r = (bi >= 8) ? 0 : ((ai << bi) & 255);
            4'd11: r = (bi >= 8) ? 0 : (ai >> bi);
            4'd12: r = ai + 1;
            4'd13: r = (ai - 1) & 255;
            4'd14: r = (ai == bi) ? 1 : 0;
            default: r = (ai > bi) ? 1 : 0;
        endcase
        return r[7:0];
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic [7:0] expected, input string name);
        sb_entry_t e;
        @(negedge clk);
        reset   = rst;
        op_code = op;
        inp1    = a;
        inp2    = b;
        e.expected = expected;
        e.name     = name;
        exp_q.push_back(e);
    endtask

    // Monitor: the register updates on every rising edge, so one entry retires per cycle.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e.name, outp, e.expected);
            end
        end
    end

    initial begin
        logic       r;
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;

        reset   = 1'b1;
        op_code = 4'd0;
        inp1    = 4'd0;
        inp2    = 4'd0;

        applyStimulus(1'b1, 4'd0,  4'hF, 4'hF, 8'h00, "reset_hold_1");
        applyStimulus(1'b1, 4'd0,  4'hF, 4'hF, 8'h00, "reset_hold_2");
        applyStimulus(1'b0, 4'd0,  4'hF, 4'hF, 8'h1E, "reset_release_add");
        applyStimulus(1'b0, 4'd1,  4'h3, 4'h5, 8'hFE, "sub_wrap");
        applyStimulus(1'b0, 4'd13, 4'h0, 4'h0, 8'hFF, "dec_wrap");
        applyStimulus(1'b0, 4'd2,  4'hF, 4'hF, 8'hE1, "mul_max");
        applyStimulus(1'b0, 4'd0,  4'h9, 4'h8, 8'h11, "add_carry");

        // Raising reset between edges must not disturb the held result.
        applyStimulus(1'b1, 4'd2,  4'hF, 4'hF, 8'h00, "reset_sync_edge");
        #2;
        checkOutput("reset_no_async", outp, 8'h11);

        applyStimulus(1'b0, 4'd10, 4'hF, 4'h4, 8'hF0, "shl_4");
        applyStimulus(1'b0, 4'd10, 4'hF, 4'h8, 8'h00, "shl_oob");
        applyStimulus(1'b0, 4'd11, 4'hC, 4'h2, 8'h03, "shr_2");
        applyStimulus(1'b0, 4'd11, 4'hF, 4'h8, 8'h00, "shr_oob");
        applyStimulus(1'b0, 4'd3,  4'hC, 4'hA, 8'h08, "b2b_and");
        applyStimulus(1'b0, 4'd6,  4'hC, 4'hA, 8'h07, "b2b_nand");
        applyStimulus(1'b0, 4'd14, 4'h5, 4'h5, 8'h01, "b2b_eq");
        applyStimulus(1'b0, 4'd15, 4'h3, 4'h7, 8'h00, "b2b_gt");
        applyStimulus(1'b0, 4'd4,  4'hC, 4'hA, 8'h0E, "or");
        applyStimulus(1'b0, 4'd5,  4'hC, 4'hA, 8'h06, "xor");
        applyStimulus(1'b0, 4'd7,  4'hC, 4'hA, 8'h01, "nor");
        applyStimulus(1'b0, 4'd8,  4'hC, 4'hA, 8'h09, "xnor");
        applyStimulus(1'b0, 4'd9,  4'h5, 4'h0, 8'h0A, "not_a");
        applyStimulus(1'b0, 4'd12, 4'hF, 4'h0, 8'h10, "inc_carry");
        applyStimulus(1'b0, 4'd15, 4'h7, 4'h3, 8'h01, "gt_true");

        applyStimulus(1'b0, 4'd2,  4'h7, 4'h9, 8'h3F, "mul_stream_1");
        applyStimulus(1'b0, 4'd2,  4'hD, 4'hB, 8'h8F, "mul_stream_2");
        applyStimulus(1'b1, 4'd2,  4'hF, 4'hF, 8'h00, "mul_stream_reset");
        applyStimulus(1'b0, 4'd0,  4'h1, 4'h2, 8'h03, "post_reset_add");

        for (int i = 0; i < 1200; i++) begin
            r  = ($urandom_range(0, 99) < 3);
            op = 4'($urandom_range(0, 15));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            applyStimulus(r, op, a, b, r ? 8'h00 : model(op, a, b), "random");
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter N, default 4, SHALL set the operand width in bits (N >= 2).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 op_code  input  4  SHALL select the operation per REQ-008.
REQ-005 inp1  input  N  SHALL be operand A, unsigned.
REQ-006 inp2  input  N  SHALL be operand B, unsigned.
REQ-007 outp  output  2N  SHALL be the registered result.

Function
REQ-008 The op_code encoding SHALL be as follows. Operands are zero-extended to 2N bits before the operation unless stated otherwise.
- 0 ADD: A+B.
- 1 SUB: (A-B) mod 2^(2N).
- 2 MUL: A*B, full 2N-bit product.
- 3 AND.
- 4 OR.
- 5 XOR.
- 6 NAND: ~(A&B), N bits, upper N bits 0.
- 7 NOR: N bits, upper N bits 0.
- 8 XNOR: N bits, upper N bits 0.
- 9 NOT A: N bits, upper N bits 0.
- 10 SHL: A << B, result in 2N bits.
- 11 SHR: A >> B, logical.
- 12 INC: A+1.
- 13 DEC: (A-1) mod 2^(2N).
- 14 EQ: 1 if A==B, else 0.
- 15 GT: 1 if A>B, else 0.
REQ-009 outp SHALL update exactly one clock after op_code/inp1/inp2 are sampled (latency 1, registered output, no combinational input-to-output path).
REQ-010 A new operation SHALL be accepted every cycle (throughput 1); there is no handshake.
REQ-011 outp SHALL hold its value only while inputs repeat; it recomputes every non-reset cycle.
REQ-012 SHL and SHR SHALL produce 0 when B >= 2N.
REQ-013 ADD and INC SHALL never wrap for any N (the carry appears in bit N).
REQ-014 SUB and DEC SHALL wrap modulo 2^(2N) when the result is negative, e.g. 0-1 = all ones.
REQ-015 MUL SHALL never overflow; the maximum is (2^N-1)^2.
REQ-016 Unknown/X inputs are out of scope; all 16 codes are defined, so no default error state exists.

Reset
REQ-017 When reset=1 at a rising clk edge, outp SHALL become 0 on that edge, regardless of op_code/inp1/inp2.
REQ-018 While reset is held, outp SHALL stay 0.
REQ-019 On the first edge with reset=0, outp SHALL take the result of the inputs sampled at that edge.
REQ-020 Asserting reset mid-stream SHALL discard the in-flight result; no value computed before reset SHALL appear afterward.
REQ-021 Reset SHALL have no asynchronous effect: raising reset between edges leaves outp unchanged until the next edge.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (N=4):
- reset=1 for 2 cycles with op=0, A=15, B=15 -> outp=0x00 throughout; release reset -> outp=0x1E one cycle later.
- op=1 (SUB), A=3, B=5 -> outp=0xFE; op=13 (DEC), A=0 -> outp=0xFF.
- op=2 (MUL), A=15, B=15 -> outp=0xE1; op=0 (ADD), A=9, B=8 -> outp=0x11.
- op=10 (SHL), A=0xF, B=4 -> 0xF0; B=8 -> 0x00; op=11 (SHR), A=0xC, B=2 -> 0x03.
- Back-to-back ops AND(0xC,0xA), NAND(0xC,0xA), EQ(5,5), GT(3,7) on consecutive cycles -> outp=0x08, 0x07, 0x01, 0x00 on consecutive cycles, one-cycle lag.
- Reset asserted during a MUL stream -> outp=0 on the reset edge; the first post-reset output matches only the post-reset inputs.
REQ-023 The bench SHALL compare outp each cycle against a reference model of REQ-008 using the inputs from the previous cycle, and SHALL run at least 1000 random cycles over all op codes.
